// File: rtl/trap_ctrl_v2.sv
// Machine-mode trap controller: synchronised level/edge interrupts, fixed
// exception priority, direct/vectored target, and a request/flush/commit handshake.

module trap_irq_lane #(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    input  logic clr,
    output logic pend
);
    logic s1, s2, s3, p;

    // s3 lags s2 by one cycle so an edge pends one cycle after the level view
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= irq_raw;
            s2 <= s1;
            s3 <= s2;
            if (IS_EDGE) begin
                if (s2 && !s3)
                    p <= 1'b1;
                else if (clr)
                    p <= 1'b0;
            end
        end
    end

    assign pend = IS_EDGE ? p : s2;
endmodule

module trap_ctrl_v2 #(
    parameter int                 NUM_IRQ   = 16,
    parameter int                 XLEN      = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    mtvec,
    input  logic               mstatus_mie,
    input  logic [NUM_IRQ-1:0] mie,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_clear,
    input  logic [4:0]         exc_vec,
    input  logic [XLEN-1:0]    epc_in,
    input  logic               flush_ack,
    output logic [NUM_IRQ-1:0] mip_out,
    output logic               trap_req,
    output logic               trap_is_irq,
    output logic [XLEN-1:0]    trap_pc,
    output logic [XLEN-1:0]    cause,
    output logic [XLEN-1:0]    mepc_out,
    output logic               commit,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, REQ, COMMIT} state_t;

    state_t             state, state_nxt;
    logic               capture;
    logic [NUM_IRQ-1:0] pending, irq_act, commit_clr;
    logic               irq_ok, take_exc;
    logic [4:0]         exc_code, irq_code, nxt_code;
    logic [XLEN-1:0]    base, nxt_pc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_lane
            assign commit_clr[gi] = commit && trap_is_irq && (cause[4:0] == 5'(gi));
            trap_irq_lane #(.IS_EDGE(EDGE_MASK[gi])) u_lane (
                .clk     (clk),
                .reset   (reset),
                .irq_raw (irq_in[gi]),
                .clr     (irq_clear[gi] | commit_clr[gi]),
                .pend    (pending[gi])
            );
        end
    endgenerate

    assign mip_out  = pending;
    assign irq_act  = pending & mie;
    assign irq_ok   = mstatus_mie & (|irq_act);
    assign take_exc = |exc_vec;

    always_comb begin
        exc_code = 5'd0;
        if      (exc_vec[0]) exc_code = 5'd0;
        else if (exc_vec[1]) exc_code = 5'd2;
        else if (exc_vec[2]) exc_code = 5'd4;
        else if (exc_vec[3]) exc_code = 5'd6;
        else if (exc_vec[4]) exc_code = 5'd11;
    end

    // Scan downward so the lowest active channel is the last one written
    always_comb begin
        irq_code = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (irq_act[i]) irq_code = 5'(i);
    end

    assign nxt_code = take_exc ? exc_code : irq_code;
    assign base     = {mtvec[XLEN-1:2], 2'b00};
    assign nxt_pc   = (mtvec[1:0] == 2'b01 && !take_exc)
                    ? base + ({{(XLEN-5){1'b0}}, nxt_code} << 2) : base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (take_exc || irq_ok) begin
                capture   = 1'b1;
                state_nxt = REQ;
            end
            REQ:     if (flush_ack) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_is_irq <= 1'b0;
            trap_pc     <= '0;
            cause       <= '0;
            mepc_out    <= '0;
        end else if (capture) begin
            trap_is_irq <= !take_exc;
            trap_pc     <= nxt_pc;
            cause       <= {!take_exc, {(XLEN-6){1'b0}}, nxt_code};
            mepc_out    <= epc_in;
        end
    end

    assign trap_req = (state == REQ);
    assign commit   = (state == COMMIT);
    assign busy     = (state != IDLE);
endmodule

// File: doc/trap_ctrl_v2.md
Name: trap_ctrl_v2

Overview:
Parametrised machine-mode trap controller for the core datapath CSR blocks. It handles NUM_IRQ interrupt lines, each configurable as level or edge, with synchronisers and pending latches. It prioritises synchronous exceptions over interrupts and computes the direct or vectored trap target. A request/flush/commit FSM freezes the trap until the pipeline acknowledges, then pulses the mepc/mcause writes to the CSR file.

Parameters:
NUM_IRQ, 16, number of interrupt channels (1..32); channel i maps to cause code i.
XLEN, 32, address/CSR width.
EDGE_MASK, 0, NUM_IRQ-bit mask; bit i=1 makes channel i edge-triggered, 0 makes it level.

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
mtvec  input  XLEN  trap vector CSR; [1:0]=mode
mstatus_mie  input  1  global machine interrupt enable
mie  input  NUM_IRQ  per-channel enables
irq_in  input  NUM_IRQ  raw asynchronous interrupt lines
irq_clear  input  NUM_IRQ  W1C clear of edge-pending bits (from mip CSR write)
exc_vec  input  5  {ecall, store_mis, load_mis, illegal, inst_addr_mis}, valid in MEM stage
epc_in  input  XLEN  PC of the instruction in MEM
flush_ack  input  1  pipeline flushed and ready to redirect
mip_out  output  NUM_IRQ  current pending bits
trap_req  output  1  trap pending; pipeline must flush
trap_is_irq  output  1  frozen trap is an interrupt
trap_pc  output  XLEN  frozen redirect target
cause  output  XLEN  frozen mcause value
mepc_out  output  XLEN  frozen mepc value
commit  output  1  one-cycle pulse: CSR file writes mepc/mcause; fetch redirects to trap_pc
busy  output  1  FSM not IDLE

Behaviour:
- Reset (async, any state): FSM=IDLE; sync flops, pending, and all outputs = 0.
- Synchroniser: 2-flop per channel (s[i]); a raw edge is visible in mip_out 2 cycles after it reaches irq_in (3 for edge channels: edge-detect flop).
- Level channel: pending[i] = s[i]; irq_clear has no effect.
- Edge channel: pending[i] sets on a 0->1 transition of s[i]. It clears on irq_clear[i] or on commit of a trap with code i. Set and clear in the same cycle: set wins.
- mip_out = pending.
- irq_ok = mstatus_mie & |(pending & mie). Exceptions ignore mstatus_mie and mie.
- Exception priority (fixed, highest first):
  - inst_addr_mis -> code 0
  - illegal -> 2
  - load_mis -> 4
  - store_mis -> 6
  - ecall -> 11
- Interrupt priority: lowest channel index wins among pending&mie.
- Exceptions beat interrupts on the same cycle.
- cause = {1'b1, (XLEN-6)'b0, code} for an interrupt; {1'b0, ..., code} for an exception. code is 5 bits, zero-extended.
- trap_pc: mtvec[1:0]==2'b01 and interrupt -> {mtvec[XLEN-1:2],2'b00} + (code<<2), modulo 2^XLEN. Otherwise (exceptions, mode 00, reserved modes 1x) -> {mtvec[XLEN-1:2],2'b00}.
- FSM:
  - IDLE: if |exc_vec or irq_ok, capture cause, trap_pc, trap_is_irq, and mepc_out=epc_in, then go to REQ the next cycle.
  - REQ: trap_req=1; captured values held stable. exc_vec and irq changes are ignored; pending continues to accumulate. flush_ack=1 -> COMMIT.
  - COMMIT: commit=1 for exactly one cycle; auto-clears the edge pending bit if trap_is_irq; -> IDLE.
  - Next trap can be captured the cycle after COMMIT. IDLE->REQ->COMMIT minimum is 3 cycles with flush_ack tied high.
- trap_req deasserts in COMMIT. busy=1 in REQ and COMMIT.
- flush_ack outside REQ is ignored.
- A level interrupt that drops during REQ is still taken (frozen).

Test Plan:
- Exception priority: exc_vec=5'b10110, mtvec=0x8000_0001 -> cause=0x0000_0002, trap_pc=0x8000_0000 (exceptions never vectored). commit pulses 1 cycle after flush_ack.
- Vectored IRQ: mtvec=0x8000_0001, mie=0xFFFF, mstatus_mie=1, irq_in[5] and irq_in[9] rise -> cause=0x8000_0005, trap_pc=0x8000_0014. After commit, channel 9 is taken next: 0x8000_0009, 0x8000_0024.
- Edge latching: EDGE_MASK bit3=1, 1-cycle pulse on irq_in[3] with mstatus_mie=0 -> mip_out[3]=1 three cycles later and held. irq_clear[3] with a coincident new edge -> stays 1. irq_clear alone -> 0.
- Freeze: in REQ with flush_ack=0 for 10 cycles, assert ecall and drop a level IRQ -> cause, trap_pc, and mepc_out unchanged. Ecall is taken after commit.
- Masking/wrap: mie=0 or mstatus_mie=0 with pending=0xFFFF -> no trap_req. mtvec=0xFFFF_FFFD, IRQ 2 -> trap_pc=0x0000_0004 (wraps).
- Async reset asserted in REQ -> all outputs 0 immediately; after release with no events, remains in IDLE.
